// File: rtl/cv32e40p_nmr_monitor.sv
// N-modular-redundancy voter with per-replica error counters that retire replicas which keep disagreeing.
// Votes combinationally, and state changes on clk. FT_NMR_RECOVERY_EN enables probation and readmission of repaired replicas.
module cv32e40p_nmr_monitor #(
  parameter int NREP               = 3,
  parameter int W                  = 32,
  parameter int INCREMENT          = 4,
  parameter int DECREMENT          = 1,
  parameter int BREAKING_THRESHOLD = 16,
  parameter int COUNT_BIT          = 5,
  parameter int RECOVER_CYCLES     = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic [NREP*W-1:0]   to_vote_i,
  input  logic [NREP-1:0]     set_broken_i,
  output logic [W-1:0]        voted_o,
  output logic [NREP-1:0]     block_err_o,
  output logic [NREP-1:0]     is_broken_o,
  output logic                err_detected_o,
  output logic                err_corrected_o,
  output logic [1:0]          mode_o,
  output logic                fail_o
);

  localparam int IW = $clog2(NREP);
  localparam int CW = COUNT_BIT;
  localparam logic [CW:0]   CNT_MAX = {1'b0, {CW{1'b1}}};
  localparam logic [CW:0]   INC     = (CW+1)'(INCREMENT);
  localparam logic [CW-1:0] DEC     = CW'(DECREMENT);
  localparam logic [CW-1:0] THR     = CW'(BREAKING_THRESHOLD);

  if (NREP < 3 || NREP > 7 || BREAKING_THRESHOLD >= (1 << COUNT_BIT) || RECOVER_CYCLES < 1) begin : g_bad_cfg
    $error("cv32e40p_nmr_monitor: unsupported parameter set");
  end

  logic [W-1:0]    rep [NREP];
  logic [NREP-1:0] alive;
  logic [2:0]      n_alive;
  logic [IW-1:0]   lo_idx;
  logic [IW-1:0]   hi_idx;
  logic [W-1:0]    maj;
  logic [W-1:0]    tie_bits;
  logic [NREP-1:0] diff;

  logic [CW-1:0]   cnt      [NREP];
  logic [CW-1:0]   cnt_nxt  [NREP];
  logic [CW:0]     cnt_sum  [NREP];
  logic [CW-1:0]   cnt_upd  [NREP];
  logic [NREP-1:0] forced;
  logic [NREP-1:0] forced_nxt;
  logic [NREP-1:0] broken_nxt;

  assign alive = ~is_broken_o;

  for (genvar i = 0; i < NREP; i++) begin : g_rep
    assign rep[i]     = to_vote_i[i*W +: W];
    assign cnt_sum[i] = {1'b0, cnt[i]} + INC;
    assign cnt_upd[i] = block_err_o[i] ? ((cnt_sum[i] > CNT_MAX) ? CNT_MAX[CW-1:0] : cnt_sum[i][CW-1:0])
                                       : ((cnt[i] >= DEC) ? (cnt[i] - DEC) : '0);
  end

  always_comb begin
    n_alive = '0;
    lo_idx  = '0;
    hi_idx  = '0;
    for (int i = NREP - 1; i >= 0; i--) begin
      if (alive[i]) begin
        n_alive = n_alive + 3'd1;
        lo_idx  = IW'(i);
      end
    end
    for (int i = 0; i < NREP; i++) begin
      if (alive[i]) hi_idx = IW'(i);
    end
  end

  // A bit is tied when exactly half the live replicas hold a one; fall back to the lowest live replica.
  for (genvar b = 0; b < W; b++) begin : g_bit
    logic [2:0] ones;
    always_comb begin
      ones = '0;
      for (int i = 0; i < NREP; i++) ones = ones + {2'b0, alive[i] & rep[i][b]};
    end
    assign tie_bits[b] = ({ones, 1'b0} == {1'b0, n_alive});
    assign maj[b]      = tie_bits[b] ? rep[lo_idx][b] : ({ones, 1'b0} > {1'b0, n_alive});
  end

  always_comb begin
    for (int i = 0; i < NREP; i++) diff[i] = alive[i] && (rep[i] != maj);
  end

  always_comb begin
    if (n_alive >= 3'd3)      mode_o = 2'd0;
    else if (n_alive == 3'd2) mode_o = 2'd1;
    else if (n_alive == 3'd1) mode_o = 2'd2;
    else                      mode_o = 2'd3;
  end

  assign fail_o = (mode_o == 2'd3);

  always_comb begin
    voted_o         = rep[0];
    block_err_o     = '0;
    err_detected_o  = 1'b0;
    err_corrected_o = 1'b0;
    case (mode_o)
      2'd0: begin
        voted_o = maj;
        if (|tie_bits) begin
          err_detected_o = 1'b1;
        end else begin
          block_err_o     = diff;
          err_detected_o  = |diff;
          err_corrected_o = |diff;
        end
      end
      2'd1: begin
        voted_o        = rep[lo_idx];
        err_detected_o = (rep[lo_idx] != rep[hi_idx]);
      end
      2'd2:    voted_o = rep[lo_idx];
      default: voted_o = rep[0];
    endcase
  end

`ifdef FT_NMR_RECOVERY_EN
  localparam int PW = $clog2(RECOVER_CYCLES + 1);
  localparam logic [PW-1:0] PROB_LAST = PW'(RECOVER_CYCLES - 1);

  logic [PW-1:0]   prob     [NREP];
  logic [PW-1:0]   prob_nxt [NREP];
  logic [NREP-1:0] eligible;
  logic [NREP-1:0] match;

  always_comb begin
    for (int i = 0; i < NREP; i++) begin
      eligible[i] = is_broken_o[i] && !forced[i] && (n_alive >= 3'd2);
      match[i]    = (rep[i] == voted_o);
    end
  end
`endif

  always_comb begin
    for (int i = 0; i < NREP; i++) begin
      cnt_nxt[i]    = cnt[i];
      broken_nxt[i] = is_broken_o[i];
      forced_nxt[i] = forced[i];
      if (alive[i] && valid_i) begin
        cnt_nxt[i] = cnt_upd[i];
        if (cnt_upd[i] >= THR) broken_nxt[i] = 1'b1;
      end
`ifdef FT_NMR_RECOVERY_EN
      prob_nxt[i] = prob[i];
      if (!eligible[i]) begin
        prob_nxt[i] = '0;
      end else if (valid_i) begin
        if (!match[i]) begin
          prob_nxt[i] = '0;
        end else if (prob[i] == PROB_LAST) begin
          prob_nxt[i]   = '0;
          cnt_nxt[i]    = '0;
          broken_nxt[i] = 1'b0;
        end else begin
          prob_nxt[i] = prob[i] + PW'(1);
        end
      end
`endif
      // A forced break overrides anything else decided this cycle.
      if (set_broken_i[i]) begin
        broken_nxt[i] = 1'b1;
        forced_nxt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_broken_o <= '0;
      forced      <= '0;
      for (int i = 0; i < NREP; i++) begin
        cnt[i] <= '0;
`ifdef FT_NMR_RECOVERY_EN
        prob[i] <= '0;
`endif
      end
    end else begin
      is_broken_o <= broken_nxt;
      forced      <= forced_nxt;
      for (int i = 0; i < NREP; i++) begin
        cnt[i] <= cnt_nxt[i];
`ifdef FT_NMR_RECOVERY_EN
        prob[i] <= prob_nxt[i];
`endif
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_nmr_monitor.sv
// Randomised and directed check of cv32e40p_nmr_monitor (NREP=3/W=32 and NREP=4/W=8) against a behavioural model.
module tb_cv32e40p_nmr_monitor;

  localparam int RC = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic valid = 1'b0;
  always #5 clk = ~clk;

  logic [95:0] tv3;
  logic [2:0]  sb3, be3, br3;
  logic [31:0] voted3;
  logic        det3, cor3, fail3;
  logic [1:0]  mode3;

  logic [31:0] tv4;
  logic [3:0]  sb4, be4, br4;
  logic [7:0]  voted4;
  logic        det4, cor4, fail4;
  logic [1:0]  mode4;

  cv32e40p_nmr_monitor #(.NREP(3), .W(32), .RECOVER_CYCLES(RC)) dut3 (
    .clk(clk), .rst(rst), .valid_i(valid), .to_vote_i(tv3), .set_broken_i(sb3),
    .voted_o(voted3), .block_err_o(be3), .is_broken_o(br3), .err_detected_o(det3),
    .err_corrected_o(cor3), .mode_o(mode3), .fail_o(fail3));

  cv32e40p_nmr_monitor #(.NREP(4), .W(8), .RECOVER_CYCLES(RC)) dut4 (
    .clk(clk), .rst(rst), .valid_i(valid), .to_vote_i(tv4), .set_broken_i(sb4),
    .voted_o(voted4), .block_err_o(be4), .is_broken_o(br4), .err_detected_o(det4),
    .err_corrected_o(cor4), .mode_o(mode4), .fail_o(fail4));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Model state, [instance][replica]; instance 0 = 3x32, instance 1 = 4x8.
  int          m_cnt [2][8];
  int          m_prb [2][8];
  bit          m_brk [2][8];
  bit          m_frc [2][8];
  bit          m_sb  [2][8];
  logic [31:0] m_val [2][8];

  logic [31:0] e_vot [2];
  bit          e_be  [2][8];
  bit          e_det [2];
  bit          e_cor [2];
  int          e_mode[2];
  int          e_live[2];

  function automatic int nrep(int k); return (k == 0) ? 3 : 4; endfunction
  function automatic int wid(int k);  return (k == 0) ? 32 : 8; endfunction

  function automatic void model_clear();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) begin
        m_cnt[k][i] = 0; m_prb[k][i] = 0; m_brk[k][i] = 0; m_frc[k][i] = 0; m_sb[k][i] = 0;
      end
  endfunction

  function automatic void model_eval(int k);
    int a, lo, hi, ones;
    bit tie;
    logic [31:0] v;
    a = 0; lo = -1; hi = -1; tie = 0; v = '0;
    for (int i = 0; i < nrep(k); i++) begin
      e_be[k][i] = 0;
      if (!m_brk[k][i]) begin
        a++;
        if (lo < 0) lo = i;
        hi = i;
      end
    end
    e_live[k] = a;
    e_mode[k] = (a >= 3) ? 0 : (a == 2) ? 1 : (a == 1) ? 2 : 3;
    e_det[k] = 0; e_cor[k] = 0;
    if (a == 0) begin
      e_vot[k] = m_val[k][0];
    end else if (a <= 2) begin
      e_vot[k] = m_val[k][lo];
      if (a == 2) e_det[k] = (m_val[k][lo] != m_val[k][hi]);
    end else begin
      for (int b = 0; b < wid(k); b++) begin
        ones = 0;
        for (int i = 0; i < nrep(k); i++) if (!m_brk[k][i] && m_val[k][i][b]) ones++;
        if (2 * ones > a) v[b] = 1'b1;
        else if (2 * ones == a) begin tie = 1; v[b] = m_val[k][lo][b]; end
      end
      e_vot[k] = v;
      if (tie) e_det[k] = 1;
      else
        for (int i = 0; i < nrep(k); i++)
          if (!m_brk[k][i] && m_val[k][i] != v) begin
            e_be[k][i] = 1; e_det[k] = 1; e_cor[k] = 1;
          end
    end
  endfunction

  function automatic void model_clock(int k);
    for (int i = 0; i < nrep(k); i++) begin
      if (!m_brk[k][i]) begin
        if (valid) begin
          if (e_be[k][i]) m_cnt[k][i] = (m_cnt[k][i] + 4 > 31) ? 31 : m_cnt[k][i] + 4;
          else            m_cnt[k][i] = (m_cnt[k][i] > 0) ? m_cnt[k][i] - 1 : 0;
          if (m_cnt[k][i] >= 16) m_brk[k][i] = 1;
        end
      end else begin
`ifdef FT_NMR_RECOVERY_EN
        if (!m_frc[k][i] && e_live[k] >= 2) begin
          if (valid) begin
            if (m_val[k][i] == e_vot[k]) begin
              m_prb[k][i]++;
              if (m_prb[k][i] == RC) begin m_brk[k][i] = 0; m_cnt[k][i] = 0; m_prb[k][i] = 0; end
            end else m_prb[k][i] = 0;
          end
        end else m_prb[k][i] = 0;
`endif
      end
      if (m_sb[k][i]) begin m_brk[k][i] = 1; m_frc[k][i] = 1; end
    end
  endfunction

  function automatic logic [7:0] pk_brk(int k);
    logic [7:0] r; r = '0;
    for (int i = 0; i < nrep(k); i++) r[i] = m_brk[k][i];
    return r;
  endfunction

  function automatic logic [7:0] pk_be(int k);
    logic [7:0] r; r = '0;
    for (int i = 0; i < nrep(k); i++) r[i] = e_be[k][i];
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < 3; i++) begin tv3[i*32 +: 32] = m_val[0][i]; sb3[i] = m_sb[0][i]; end
    for (int i = 0; i < 4; i++) begin tv4[i*8 +: 8] = m_val[1][i][7:0]; sb4[i] = m_sb[1][i]; end
  endtask

  task automatic compare_all();
    model_eval(0);
    model_eval(1);
    check("voted3", voted3, e_vot[0]);
    check("blkerr3", be3, pk_be(0));
    check("det3", det3, e_det[0]);
    check("cor3", cor3, e_cor[0]);
    check("mode3", mode3, e_mode[0]);
    check("fail3", fail3, e_mode[0] == 3);
    check("broken3", br3, pk_brk(0));
    check("voted4", voted4, e_vot[1]);
    check("blkerr4", be4, pk_be(1));
    check("det4", det4, e_det[1]);
    check("cor4", cor4, e_cor[1]);
    check("mode4", mode4, e_mode[1]);
    check("fail4", fail4, e_mode[1] == 3);
    check("broken4", br4, pk_brk(1));
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic cycle();
    drive();
    #2;
    compare_all();
    @(posedge clk);
    model_clock(0);
    model_clock(1);
    #1;
    for (int k = 0; k < 2; k++) for (int i = 0; i < 8; i++) m_sb[k][i] = 0;
  endtask

  task automatic do_reset();
    valid = 1'b0;
    for (int k = 0; k < 2; k++) for (int i = 0; i < 8; i++) m_sb[k][i] = 0;
    drive();
    #2 rst = 1'b1;
    model_clear();
    #1;
    check("rst_broken3", br3, 3'b000);
    check("rst_mode3", mode3, 2'd0);
    check("rst_fail3", fail3, 1'b0);
    check("rst_broken4", br4, 4'b0000);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic set3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    m_val[0][0] = a; m_val[0][1] = b; m_val[0][2] = c;
  endtask

  logic [31:0] base;
  int          pct;

  initial begin
    for (int k = 0; k < 2; k++) for (int i = 0; i < 8; i++) m_val[k][i] = '0;
    model_clear();
    drive();
    @(posedge clk);
    #1;
    do_reset();

    valid = 1'b1;
    set3(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    cycle();
    check("agree_voted", voted3, 32'hDEADBEEF);
    check("agree_det", det3, 1'b0);
    check("agree_blkerr", be3, 3'b000);

    set3(32'h12345678, 32'h0, 32'h12345678);
    cycle();
    check("maj_voted", voted3, 32'h12345678);
    check("maj_blkerr", be3, 3'b010);
    check("maj_cor", cor3, 1'b1);
    cycle();
    cycle();
    check("maj_not_yet_broken", br3, 3'b000);
    cycle();
    check("maj_broken", br3, 3'b010);
    check("maj_mode_duplex", mode3, 2'd1);

    do_reset();
    valid = 1'b1;
    set3(32'hFF, 32'h0, 32'h0);
    cycle();
    set3(32'h0, 32'h0, 32'h0);
    repeat (3) cycle();
    check("decay_broken", br3, 3'b000);
    set3(32'hFF, 32'h0, 32'h0);
    repeat (3) cycle();
    check("accum13_broken", br3, 3'b000);
    do_reset();
    valid = 1'b1;
    repeat (3) cycle();
    check("after_rst_12", br3, 3'b000);
    cycle();
    check("after_rst_16", br3, 3'b001);

    do_reset();
    m_sb[0][2] = 1;
    cycle();
    valid = 1'b1;
    set3(32'hA, 32'hB, 32'hC);
    cycle();
    check("forced_broken", br3, 3'b100);
    check("duplex_voted", voted3, 32'hA);
    check("duplex_det", det3, 1'b1);
    check("duplex_cor", cor3, 1'b0);
    check("duplex_blkerr", be3, 3'b000);

    m_val[1][0] = 32'hF; m_val[1][1] = 32'hF; m_val[1][2] = 32'h0; m_val[1][3] = 32'h0;
    cycle();
    check("tie_voted", voted4, 8'h0F);
    check("tie_det", det4, 1'b1);
    check("tie_cor", cor4, 1'b0);
    check("tie_blkerr", be4, 4'b0000);

    do_reset();
    valid = 1'b1;
    set3(32'h55, 32'h66, 32'h55);
    repeat (4) cycle();
    check("rec_broken", br3, 3'b010);
    set3(32'h55, 32'h55, 32'h55);
    repeat (4) cycle();
    set3(32'h55, 32'h66, 32'h55);
    cycle();
    set3(32'h55, 32'h55, 32'h55);
    repeat (7) cycle();
    check("rec_still_broken", br3, 3'b010);
    cycle();
`ifdef FT_NMR_RECOVERY_EN
    check("rec_readmitted", br3, 3'b000);
`else
    check("rec_sticky", br3, 3'b010);
`endif

    do_reset();
    valid = 1'b1;
    m_sb[0][1] = 1;
    repeat (20) cycle();
    check("forced_never_readmit", br3, 3'b010);

    pct = 10;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        pct = $urandom_range(3, 30);
      end
      valid = ($urandom_range(0, 9) != 0);
      base = $urandom;
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < nrep(k); i++) begin
          if ($urandom_range(0, 99) < pct)
            m_val[k][i] = $urandom_range(0, 1) ? (base ^ (32'd1 << $urandom_range(0, wid(k) - 1))) : $urandom;
          else
            m_val[k][i] = base;
          if (k == 1) m_val[k][i] = m_val[k][i] & 32'hFF;
          m_sb[k][i] = ($urandom_range(0, 199) == 0);
        end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_nmr_monitor.md
# cv32e40p_nmr_monitor

Parametrised N-modular-redundancy voter with built-in per-replica breakage tracking, for use inside the `*_ft` wrappers of cv32e40p pipeline blocks. It generalises the fixed triple voter and external breakage monitor into one block:

- NREP replicas of a W-bit signal.
- Voting over live replicas only.
- Degradation from N-way vote to duplex compare to simplex.
- Optional readmission of repaired replicas.

## Interface
Parameters:
- NREP, 3: number of replicas, 3..7.
- W, 32: width of the voted signal.
- INCREMENT, 4: counter step on a replica error.
- DECREMENT, 1: counter step on a clean cycle.
- BREAKING_THRESHOLD, 16: counter value at which a replica is declared broken.
- COUNT_BIT, 5: counter width; must hold BREAKING_THRESHOLD.
- RECOVER_CYCLES, 64: consecutive clean cycles required for readmission (used only with the recovery macro).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- valid_i  in  1  evaluation enable; counters move only when high.
- to_vote_i  in  NREP*W  replica values; replica i occupies bits [i*W +: W].
- set_broken_i  in  NREP  forces replica i broken.
- voted_o  out  W  voted value.
- block_err_o  out  NREP  replica i disagrees with a corrected vote.
- is_broken_o  out  NREP  registered broken flags.
- err_detected_o  out  1  any disagreement among live replicas.
- err_corrected_o  out  1  disagreement masked by a majority.
- mode_o  out  2  live-replica class: 0 vote (A>=3), 1 duplex (A=2), 2 simplex (A=1), 3 fail (A=0).
- fail_o  out  1  mode_o==3.

## Operation
- A = number of replicas with is_broken_o=0.
- Vote mode (A>=3), per bit:
  - ones > A/2 gives 1; ones < A/2 gives 0.
  - ones == A/2 (even A) is a tie: take the bit of the lowest-index live replica, set err_detected_o=1, err_corrected_o=0, and block_err_o=0 for every replica in that cycle.
  - No tie and any live replica differs: err_detected_o=err_corrected_o=1; block_err_o[i]=1 for each live differing replica.
- Duplex (A=2):
  - voted_o = lowest-index live replica.
  - Mismatch sets err_detected_o=1, err_corrected_o=0, block_err_o=0.
- Simplex (A=1): voted_o = the live replica; all error outputs 0.
- Fail (A=0): voted_o = replica 0; fail_o=1.
- Broken replicas never influence voted_o, block_err_o or the error flags.
- Per live replica, on valid_i=1:
  - block_err_o[i]=1: cnt = min(cnt+INCREMENT, 2^COUNT_BIT-1).
  - Otherwise: cnt = max(cnt-DECREMENT, 0).
- cnt >= BREAKING_THRESHOLD after the update sets is_broken_o[i] at that edge.
- set_broken_i[i]=1 sets is_broken_o[i] and the forced[i] flag at the next edge, regardless of valid_i.
- Several replicas may break on the same edge, including down to A=0.
- Per-replica state: HEALTHY (counting) -> BROKEN (threshold or forced). Without recovery, BROKEN is left only by rst.

## Timing
- voted_o, block_err_o, err_detected_o and err_corrected_o are combinational from to_vote_i and the registered is_broken_o.
- mode_o and fail_o are combinational from is_broken_o.
- Counters and is_broken_o update on the rising clk edge. A newly broken replica is excluded from the vote from the next cycle.
- rst clears asynchronously: all counters, probation counters, forced flags and is_broken_o go to 0. After reset: mode_o=0, fail_o=0.
- rst mid-count discards all accumulated state immediately.
- valid_i=0 freezes counters; set_broken_i still acts.

## Configuration
- FT_NMR_RECOVERY_EN defined:
  - A BROKEN replica with forced[i]=0 enters probation while A>=2.
  - Each valid_i cycle where it equals voted_o increments its probation counter; a mismatch clears the counter.
  - At RECOVER_CYCLES matches: is_broken_o[i] clears and cnt=0 at that edge; the replica votes from the next cycle.
  - Forced replicas are never readmitted.
- FT_NMR_RECOVERY_EN undefined:
  - No probation logic is generated.
  - BROKEN is sticky until rst.

## Test plan
Defaults are NREP=3, W=32 unless stated.
- All replicas 0xDEADBEEF, valid_i=1 -> voted_o=0xDEADBEEF, err flags 0, block_err_o=3'b000.
- Replica 1=0x0, others 0x12345678 for 4 valid cycles -> voted_o=0x12345678, block_err_o=3'b010, err_detected_o=err_corrected_o=1. cnt[1] goes 4,8,12,16; is_broken_o=3'b010 after the 4th edge; mode_o=1.
- One error cycle then 3 clean cycles on replica 0 -> cnt[0]=4 then 1, is_broken_o stays 0. Then assert rst mid-sequence -> cnt 0 immediately.
- set_broken_i=3'b100 pulse, then replica0=0xA, replica1=0xB -> is_broken_o=3'b100 next cycle; voted_o=0xA, err_detected_o=1, err_corrected_o=0, block_err_o=0.
- NREP=4, replicas 0xF,0xF,0x0,0x0 -> tie: voted_o=0xF, err_detected_o=1, err_corrected_o=0, block_err_o=0.
- With FT_NMR_RECOVERY_EN and RECOVER_CYCLES=8, replica 1 threshold-broken then matching for 8 valid cycles -> is_broken_o[1] clears on the 8th edge. A mismatch at cycle 5 restarts the count. Repeat with a forced break -> replica never readmitted.
